// File: rtl/op_aut_mc.sv
// Multicycle MIPS-encoded operational automaton: PC, IR, register file, ALU and next-PC
// selection, sequenced FETCH -> DECODE -> EXEC -> WB over a req/ack instruction port.
// Optional build macro OP_AUT_MC_JUMP_EN adds a jump_s input (J-type target, PC_W > 28).
module op_aut_mc #(
  parameter int unsigned     DATA_W    = 32,
  parameter int unsigned     PC_W      = 32,
  parameter int unsigned     REG_COUNT = 32,
  parameter logic [PC_W-1:0] PC_RESET  = '0
) (
  input  logic            clock,
  input  logic            reset,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [5:0]      opcode,
  output logic [5:0]      funct,
  output logic            zero,
  input  logic            rd_mux_s,
  input  logic            op2_mux_s,
  input  logic [5:0]      alu_funct,
  input  logic            write,
  input  logic            branch_mux_s,
`ifdef OP_AUT_MC_JUMP_EN
  input  logic            jump_s,
`endif
  output logic            instr_done
);

  localparam int unsigned RegAw = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

  localparam logic [1:0] StFetch  = 2'd0;
  localparam logic [1:0] StDecode = 2'd1;
  localparam logic [1:0] StExec   = 2'd2;
  localparam logic [1:0] StWb     = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [31:0]       ir_q;
  logic [DATA_W-1:0] a_q, b_q, alu_q;
  logic              zero_q;
  logic [RegAw-1:0]  dest_q;
  logic [DATA_W-1:0] rf_q [REG_COUNT];

  logic [RegAw-1:0]  rs_idx, rt_idx, rd_idx;
  logic [DATA_W-1:0] simm, op2, alu_res;
  logic [PC_W-1:0]   pc_plus4, br_off;

  assign rs_idx = ir_q[21 +: RegAw];
  assign rt_idx = ir_q[16 +: RegAw];
  assign rd_idx = ir_q[11 +: RegAw];
  assign simm   = DATA_W'($signed(ir_q[15:0]));

  // Outputs; the request is masked while reset is held so a pending fetch is abandoned.
  assign imem_req   = reset && (state_q == StFetch);
  assign imem_addr  = pc_q;
  assign opcode     = ir_q[31:26];
  assign funct      = ir_q[5:0];
  assign zero       = zero_q;
  assign instr_done = reset && (state_q == StWb);

  // ALU: operand select and function decode; unknown codes yield zero.
  always_comb begin
    op2     = op2_mux_s ? simm : b_q;
    alu_res = '0;
    case (alu_funct)
      6'h20:   alu_res = a_q + op2;
      6'h22:   alu_res = a_q - op2;
      6'h24:   alu_res = a_q & op2;
      6'h25:   alu_res = a_q | op2;
      6'h26:   alu_res = a_q ^ op2;
      6'h2A:   alu_res = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(op2))};
      default: alu_res = '0;
    endcase
  end

  // Next-PC selection; all arithmetic wraps modulo 2^PC_W.
  always_comb begin
    pc_plus4 = pc_q + PC_W'(4);
    br_off   = PC_W'($signed(ir_q[15:0])) << 2;
    pc_d     = branch_mux_s ? (pc_plus4 + br_off) : pc_plus4;
`ifdef OP_AUT_MC_JUMP_EN
    if (jump_s) pc_d = {pc_plus4[PC_W-1:28], ir_q[25:0], 2'b00};
`endif
  end

  // Sequencer next state: FETCH waits for the ack, the other states advance unconditionally.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:  if (imem_ack) state_d = StDecode;
      StDecode: state_d = StExec;
      StExec:   state_d = StWb;
      StWb:     state_d = StFetch;
      default:  state_d = StFetch;
    endcase
  end

  // Datapath registers and register file, synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= StFetch;
      pc_q    <= PC_RESET;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      zero_q  <= 1'b0;
      dest_q  <= '0;
      for (int i = 0; i < REG_COUNT; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        StFetch: begin
          if (imem_ack) ir_q <= imem_rdata;
        end
        StDecode: begin
          a_q <= rf_q[rs_idx];
          b_q <= rf_q[rt_idx];
        end
        StExec: begin
          alu_q  <= alu_res;
          zero_q <= (alu_res == '0);
          dest_q <= rd_mux_s ? rd_idx : rt_idx;
        end
        StWb: begin
          // Register 0 is never written, so it always reads zero.
          if (write && (dest_q != '0)) rf_q[dest_q] <= alu_q;
          pc_q <= pc_d;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_op_aut_mc.sv
// Directed testbench for op_aut_mc: executes hand-encoded instructions through the req/ack
// port and checks handshake, timing, zero flag and next fetch address against fixed values.
module tb_op_aut_mc;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [5:0]  opcode, funct;
  logic        zero;
  logic        rd_mux_s = 1'b0;
  logic        op2_mux_s = 1'b0;
  logic [5:0]  alu_funct = '0;
  logic        write = 1'b0;
  logic        branch_mux_s = 1'b0;
`ifdef OP_AUT_MC_JUMP_EN
  logic        jump_s = 1'b0;
`endif
  logic        instr_done;

  int n_vec = 0;
  int n_bad = 0;

  logic [2:0]  obs_done;
  logic        obs_zero, obs_stall_ok, obs_req, obs_next_req;
  logic [31:0] obs_addr, obs_next_addr;
  logic [5:0]  obs_op, obs_fn;

  op_aut_mc dut (
    .clock        (clock),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .opcode       (opcode),
    .funct        (funct),
    .zero         (zero),
    .rd_mux_s     (rd_mux_s),
    .op2_mux_s    (op2_mux_s),
    .alu_funct    (alu_funct),
    .write        (write),
    .branch_mux_s (branch_mux_s),
`ifdef OP_AUT_MC_JUMP_EN
    .jump_s       (jump_s),
`endif
    .instr_done   (instr_done)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  // Hold reset low for two cycles, release; leaves the bench just after a falling edge.
  task automatic do_reset();
    reset = 1'b0;
    imem_ack = 1'b0;
    repeat (2) begin @(negedge clock); #1; end
    reset = 1'b1;
    #1;
  endtask

  // Run one instruction from FETCH, with dly stall cycles before the ack; record observations.
  task automatic exec_instr(input logic [31:0] ir, input logic op2s, input logic [5:0] fn,
                            input logic rdms, input logic wr, input logic br, input int dly);
    logic [31:0] a0;
    logic [5:0]  op0;
    op2_mux_s = op2s; alu_funct = fn; rd_mux_s = rdms; write = wr; branch_mux_s = br;
    a0 = imem_addr;
    op0 = opcode;
    obs_stall_ok = 1'b1;
    obs_done = 3'b000;
    for (int c = 0; c < dly; c++) begin
      imem_ack = 1'b0;
      @(negedge clock); #1;
      if (imem_req !== 1'b1 || imem_addr !== a0 || opcode !== op0) obs_stall_ok = 1'b0;
    end
    obs_req = imem_req;
    obs_addr = imem_addr;
    imem_ack = 1'b1;
    imem_rdata = ir;
    @(negedge clock); #1;
    imem_ack = 1'b0;
    imem_rdata = '0;
    obs_op = opcode;
    obs_fn = funct;
    obs_done[0] = instr_done;
    @(negedge clock); #1;
    obs_done[1] = instr_done;
    @(negedge clock); #1;
    obs_done[2] = instr_done;
    obs_zero = zero;
    @(negedge clock); #1;
    obs_next_req = imem_req;
    obs_next_addr = imem_addr;
  endtask

  task automatic test_reset();
    repeat (3) begin @(negedge clock); #1; end
    n_vec++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req_low: got %b want 0", imem_req); end
    n_vec++; if (instr_done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", instr_done); end
    reset = 1'b1;
    #1;
    n_vec++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL rst_req_after: got %b want 1", imem_req); end
    n_vec++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
    n_vec++; if ({opcode, funct} !== 12'h0) begin n_bad++; $display("FAIL rst_ir: got %h want 0", {opcode, funct}); end
    n_vec++; if (zero !== 1'b0) begin n_bad++; $display("FAIL rst_zero: got %b want 0", zero); end
    // r1 = 5, then r1 - 5 leaves zero set before the mid-DECODE reset
    exec_instr(itype(6'd8, 5'd0, 5'd1, 16'd5), 1'b1, 6'h20, 1'b0, 1'b1, 1'b0, 0);
    exec_instr(itype(6'd8, 5'd1, 5'd0, 16'd5), 1'b1, 6'h22, 1'b0, 1'b0, 1'b0, 0);
    n_vec++; if (obs_zero !== 1'b1) begin n_bad++; $display("FAIL pre_rst_zero: got %b want 1", obs_zero); end
    imem_ack = 1'b1;
    imem_rdata = itype(6'd8, 5'd0, 5'd2, 16'd9);
    @(negedge clock); #1;
    imem_ack = 1'b0;
    reset = 1'b0;
    @(negedge clock); #1;
    n_vec++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL mid_rst_req1: got %b want 0", imem_req); end
    @(negedge clock); #1;
    n_vec++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL mid_rst_req2: got %b want 0", imem_req); end
    reset = 1'b1;
    #1;
    n_vec++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL mid_rst_reissue: got %b want 1", imem_req); end
    n_vec++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL mid_rst_addr: got %h want 0", imem_addr); end
    n_vec++; if (opcode !== 6'd0) begin n_bad++; $display("FAIL mid_rst_opcode: got %h want 0", opcode); end
    n_vec++; if (zero !== 1'b0) begin n_bad++; $display("FAIL mid_rst_zero: got %b want 0", zero); end
    // r1 must have been cleared: r1 + 0 == 0
    exec_instr(itype(6'd8, 5'd1, 5'd4, 16'd0), 1'b1, 6'h20, 1'b0, 1'b1, 1'b0, 0);
    n_vec++; if (obs_zero !== 1'b1) begin n_bad++; $display("FAIL rst_regs_clear: got zero=%b want 1", obs_zero); end
  endtask

  task automatic test_addi_add();
    do_reset();
    exec_instr(itype(6'd8, 5'd0, 5'd1, 16'd5), 1'b1, 6'h20, 1'b0, 1'b1, 1'b0, 0);
    n_vec++; if (obs_done !== 3'b100) begin n_bad++; $display("FAIL addi_done: got %b want 100", obs_done); end
    n_vec++; if (obs_op !== 6'd8) begin n_bad++; $display("FAIL addi_opcode: got %h want 08", obs_op); end
    n_vec++; if (obs_zero !== 1'b0) begin n_bad++; $display("FAIL addi_zero: got %b want 0", obs_zero); end
    n_vec++; if (obs_next_req !== 1'b1 || obs_next_addr !== 32'h4) begin n_bad++; $display("FAIL addi_next: got req=%b addr=%h want 1/4", obs_next_req, obs_next_addr); end
    exec_instr(rtype(5'd1, 5'd1, 5'd2, 6'h20), 1'b0, 6'h20, 1'b1, 1'b1, 1'b0, 0);
    n_vec++; if (obs_fn !== 6'h20) begin n_bad++; $display("FAIL add_funct: got %h want 20", obs_fn); end
    n_vec++; if (obs_done !== 3'b100) begin n_bad++; $display("FAIL add_done: got %b want 100", obs_done); end
    n_vec++; if (obs_next_addr !== 32'h8) begin n_bad++; $display("FAIL add_next: got %h want 8", obs_next_addr); end
    // r2 - 10 == 0 confirms r2 holds 10
    exec_instr(itype(6'd8, 5'd2, 5'd0, 16'd10), 1'b1, 6'h22, 1'b0, 1'b0, 1'b0, 0);
    n_vec++; if (obs_zero !== 1'b1) begin n_bad++; $display("FAIL add_r2_is_10: got zero=%b want 1", obs_zero); end
  endtask

  task automatic test_ack_delay();
    // PC = 0x0C; r1 ^ 5 == 0
    exec_instr(itype(6'd14, 5'd1, 5'd6, 16'd5), 1'b1, 6'h26, 1'b0, 1'b1, 1'b0, 3);
    n_vec++; if (obs_stall_ok !== 1'b1) begin n_bad++; $display("FAIL stall_stable: got %b want 1", obs_stall_ok); end
    n_vec++; if (obs_req !== 1'b1 || obs_addr !== 32'hC) begin n_bad++; $display("FAIL stall_req: got req=%b addr=%h want 1/c", obs_req, obs_addr); end
    n_vec++; if (obs_op !== 6'd14) begin n_bad++; $display("FAIL stall_ir_load: got %h want 0e", obs_op); end
    n_vec++; if (obs_done !== 3'b100) begin n_bad++; $display("FAIL stall_done: got %b want 100", obs_done); end
    n_vec++; if (obs_zero !== 1'b1) begin n_bad++; $display("FAIL xor_zero: got %b want 1", obs_zero); end
    n_vec++; if (obs_next_addr !== 32'h10) begin n_bad++; $display("FAIL stall_next: got %h want 10", obs_next_addr); end
  endtask

  task automatic test_branch();
    // PC = 0x10: r1 - r1, taken branch with simm = -2 -> 0x14 - 8
    exec_instr(itype(6'd4, 5'd1, 5'd1, 16'hFFFE), 1'b0, 6'h22, 1'b0, 1'b0, 1'b1, 0);
    n_vec++; if (obs_zero !== 1'b1) begin n_bad++; $display("FAIL br_zero: got %b want 1", obs_zero); end
    n_vec++; if (obs_next_addr !== 32'hC) begin n_bad++; $display("FAIL br_target: got %h want c", obs_next_addr); end
    exec_instr(itype(6'd8, 5'd1, 5'd0, 16'd0), 1'b1, 6'h20, 1'b0, 1'b0, 1'b0, 0);
    n_vec++; if (obs_next_addr !== 32'h10) begin n_bad++; $display("FAIL br_seq_after: got %h want 10", obs_next_addr); end
  endtask

  task automatic test_r0_slt_logic();
    exec_instr(itype(6'd8, 5'd0, 5'd0, 16'd7), 1'b1, 6'h20, 1'b0, 1'b1, 1'b0, 0);
    n_vec++; if (obs_zero !== 1'b0) begin n_bad++; $display("FAIL r0_write_alu: got zero=%b want 0", obs_zero); end
    exec_instr(itype(6'd8, 5'd0, 5'd7, 16'd0), 1'b1, 6'h20, 1'b0, 1'b1, 1'b0, 0);
    n_vec++; if (obs_zero !== 1'b1) begin n_bad++; $display("FAIL r0_reads_0: got zero=%b want 1", obs_zero); end
    exec_instr(itype(6'd8, 5'd0, 5'd8, 16'hFFFF), 1'b1, 6'h20, 1'b0, 1'b1, 1'b0, 0);
    exec_instr(itype(6'd10, 5'd8, 5'd9, 16'd1), 1'b1, 6'h2A, 1'b0, 1'b1, 1'b0, 0);
    n_vec++; if (obs_zero !== 1'b0) begin n_bad++; $display("FAIL slt_neg_lt_1: got zero=%b want 0", obs_zero); end
    exec_instr(itype(6'd8, 5'd9, 5'd0, 16'd1), 1'b1, 6'h22, 1'b0, 1'b0, 1'b0, 0);
    n_vec++; if (obs_zero !== 1'b1) begin n_bad++; $display("FAIL slt_result_1: got zero=%b want 1", obs_zero); end
    exec_instr(itype(6'd10, 5'd1, 5'd0, 16'hFFFF), 1'b1, 6'h2A, 1'b0, 1'b0, 1'b0, 0);
    n_vec++; if (obs_zero !== 1'b1) begin n_bad++; $display("FAIL slt_signed: got zero=%b want 1", obs_zero); end
    exec_instr(itype(6'd0, 5'd1, 5'd0, 16'd5), 1'b1, 6'h3F, 1'b0, 1'b0, 1'b0, 0);
    n_vec++; if (obs_zero !== 1'b1) begin n_bad++; $display("FAIL unknown_funct: got zero=%b want 1", obs_zero); end
    exec_instr(itype(6'd12, 5'd1, 5'd0, 16'd4), 1'b1, 6'h24, 1'b0, 1'b0, 1'b0, 0);
    n_vec++; if (obs_zero !== 1'b0) begin n_bad++; $display("FAIL and_5_4: got zero=%b want 0", obs_zero); end
    exec_instr(itype(6'd12, 5'd1, 5'd0, 16'd2), 1'b1, 6'h24, 1'b0, 1'b0, 1'b0, 0);
    n_vec++; if (obs_zero !== 1'b1) begin n_bad++; $display("FAIL and_5_2: got zero=%b want 1", obs_zero); end
    exec_instr(itype(6'd13, 5'd1, 5'd10, 16'd2), 1'b1, 6'h25, 1'b0, 1'b1, 1'b0, 0);
    exec_instr(itype(6'd8, 5'd10, 5'd0, 16'd7), 1'b1, 6'h22, 1'b0, 1'b0, 1'b0, 0);
    n_vec++; if (obs_zero !== 1'b1) begin n_bad++; $display("FAIL or_5_2_is_7: got zero=%b want 1", obs_zero); end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    // PC = 0, simm = -2 -> 4 - 8 wraps to 0xFFFFFFFC
    exec_instr(itype(6'd4, 5'd0, 5'd0, 16'hFFFE), 1'b0, 6'h22, 1'b0, 1'b0, 1'b1, 0);
    n_vec++; if (obs_next_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL br_neg_wrap: got %h want fffffffc", obs_next_addr); end
    exec_instr(itype(6'd8, 5'd0, 5'd0, 16'd0), 1'b1, 6'h20, 1'b0, 1'b0, 1'b0, 0);
    n_vec++; if (obs_next_addr !== 32'h0) begin n_bad++; $display("FAIL seq_wrap: got %h want 0", obs_next_addr); end
`ifdef OP_AUT_MC_JUMP_EN
    // jump overrides a simultaneously selected branch (which would give 0x14)
    jump_s = 1'b1;
    exec_instr({6'd2, 26'd4}, 1'b1, 6'h20, 1'b0, 1'b0, 1'b1, 0);
    jump_s = 1'b0;
    n_vec++; if (obs_next_addr !== 32'h10) begin n_bad++; $display("FAIL jump_target: got %h want 10", obs_next_addr); end
`endif
  endtask

  initial begin
    test_reset();
    test_addi_add();
    test_ack_delay();
    test_branch();
    test_r0_slt_logic();
    test_pc_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
